// File: rtl/sliscp_perm.sv
// sliscp_perm: iterative sLiSCP-light permutation core.
// Applies NUM_STEPS steps to a 4*WIDTH-bit state. Each step runs two Simeck
// SB boxes over S1 and S3, UNROLL rounds per clock, adds the step constants to
// S0 and S2, and applies the Feistel word mix. Constants come combinationally
// from an external ROM addressed by step_idx.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a permutation (accepted in IDLE only)
//   sin             input state {S0,S1,S2,S3}, S0 at MSBs
//   rc0, rc1        S1 / S3 box round constants, bit t used in round t
//   sc0, sc1        S0 / S2 step constants, bits [5:0] used
//   step_idx        current step, drives the constant ROM address
//   busy            high while the permutation is running
//   done            one-cycle pulse when sout becomes valid
//   sout            permuted state, held until the next done
module sliscp_perm #(
    parameter int unsigned WIDTH     = 48,
    parameter int unsigned NUM_STEPS = 18,
    parameter int unsigned SB_ROUNDS = 6,
    parameter int unsigned UNROLL    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*WIDTH-1:0]   sin,
    input  logic [7:0]           rc0,
    input  logic [7:0]           rc1,
    input  logic [7:0]           sc0,
    input  logic [7:0]           sc1,
    output logic [4:0]           step_idx,
    output logic                 busy,
    output logic                 done,
    output logic [4*WIDTH-1:0]   sout
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned SW   = 4 * WIDTH;
    // Stored round counter never holds SB_ROUNDS itself, so 3 bits cover up to 8 rounds
    localparam int unsigned RW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [SW-1:0]   st_q, st_d;
    logic [SW-1:0]   sout_q, sout_d;
    logic [4:0]      step_q, step_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WIDTH-1:0] s0, s1, s2, s3;
    logic [WIDTH-1:0] s1r, s3r;
    logic [WIDTH-1:0] mix_a, mix_b;
    logic [SW-1:0]    mixed;
    logic [RW-1:0]    idx;
    logic             last_rnd;

    // Upper sc bits are defined as don't-care
    logic unused_sc;
    assign unused_sc = ^{sc0[7:6], sc1[7:6]};

    function automatic logic [HALF-1:0] rotl(input logic [HALF-1:0] x, input int unsigned n);
        return (x << n) | (x >> (HALF - n));
    endfunction

    // One Simeck round on a word, l = upper half
    function automatic logic [WIDTH-1:0] sb_round(input logic [WIDTH-1:0] x, input logic rc);
        logic [HALF-1:0] l;
        logic [HALF-1:0] r;
        logic [HALF-1:0] f;
        l = x[WIDTH-1:HALF];
        r = x[HALF-1:0];
        f = (l & rotl(l, 5)) ^ rotl(l, 1);
        return {r ^ f ^ {{(HALF-1){1'b1}}, rc}, l};
    endfunction

    // Round datapath: UNROLL rounds on S1/S3, plus the step mix when the boxes finish
    always_comb begin
        s0  = st_q[4*WIDTH-1:3*WIDTH];
        s1  = st_q[3*WIDTH-1:2*WIDTH];
        s2  = st_q[2*WIDTH-1:WIDTH];
        s3  = st_q[WIDTH-1:0];
        s1r = s1;
        s3r = s3;
        idx = rnd_q;
        for (int u = 0; u < int'(UNROLL); u++) begin
            idx = rnd_q + RW'(u);
            s1r = sb_round(s1r, rc0[idx]);
            s3r = sb_round(s3r, rc1[idx]);
        end
        mix_a    = s0 ^ {{(WIDTH-8){1'b1}}, 2'b00, sc0[5:0]};
        mix_b    = s2 ^ {{(WIDTH-8){1'b1}}, 2'b00, sc1[5:0]};
        mixed    = {s1r, s3r ^ mix_b, s3r, mix_a ^ s1r};
        last_rnd = ({1'b0, rnd_q} + 4'(UNROLL)) == 4'(SB_ROUNDS);
    end

    // Next-state and registered-output logic
    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        sout_d = sout_q;
        step_d = step_q;
        rnd_d  = rnd_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d  = RUN;
                    st_d   = sin;
                    step_d = 5'd0;
                    rnd_d  = '0;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (last_rnd) begin
                    st_d  = mixed;
                    rnd_d = '0;
                    if (step_q == 5'(NUM_STEPS - 1)) begin
                        // step_idx stays at the final step until the next start
                        fsm_d  = DONE;
                        sout_d = mixed;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + 5'd1;
                    end
                end else begin
                    st_d  = {s0, s1r, s2, s3r};
                    rnd_d = rnd_q + RW'(UNROLL);
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            sout_q <= '0;
            step_q <= 5'd0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            sout_q <= sout_d;
            step_q <= step_d;
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign step_idx = step_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sout     = sout_q;

endmodule

// File: tb/tb_sliscp_perm.sv
// tb_sliscp_perm: directed bench for sliscp_perm.
// Three instances: WIDTH=48 UNROLL=1 (a), WIDTH=48 UNROLL=2 (b), both fed from
// the same constant table, and WIDTH=64 SB_ROUNDS=8 with zero constants (c).
// Expected states come from a loop-based reference of the permutation.
module tb_sliscp_perm;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b, start_c;
    logic [191:0] sin48;
    logic [255:0] sin64;

    logic [4:0]   step_a, step_b, step_c;
    logic         busy_a, busy_b, busy_c;
    logic         done_a, done_b, done_c;
    logic [191:0] sout_a, sout_b;
    logic [255:0] sout_c;
    logic [7:0]   rc0_a, rc1_a, sc0_a, sc1_a;
    logic [7:0]   rc0_b, rc1_b, sc0_b, sc1_b;

    int tests = 0;
    int fails = 0;

    localparam logic [191:0] S1 = 192'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
    localparam logic [191:0] S2 = 192'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0_5555_aaaa_3c3c_c3c3;

    always #5 clk = ~clk;

    // Constant table {rc0, rc1, sc0, sc1} per step
    function automatic logic [31:0] rom(input logic [4:0] i);
        logic [7:0] k;
        k = {3'b000, i};
        return {8'(k * 8'd29) ^ 8'h3C, 8'(k * 8'd53) ^ 8'hA5, 8'(k * 8'd7 + 8'd1), 8'(k * 8'd11 + 8'd9)};
    endfunction

    assign {rc0_a, rc1_a, sc0_a, sc1_a} = rom(step_a);
    assign {rc0_b, rc1_b, sc0_b, sc1_b} = rom(step_b);

    sliscp_perm #(.WIDTH(48), .NUM_STEPS(18), .SB_ROUNDS(6), .UNROLL(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sin(sin48),
        .rc0(rc0_a), .rc1(rc1_a), .sc0(sc0_a), .sc1(sc1_a),
        .step_idx(step_a), .busy(busy_a), .done(done_a), .sout(sout_a)
    );

    sliscp_perm #(.WIDTH(48), .NUM_STEPS(18), .SB_ROUNDS(6), .UNROLL(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sin(sin48),
        .rc0(rc0_b), .rc1(rc1_b), .sc0(sc0_b), .sc1(sc1_b),
        .step_idx(step_b), .busy(busy_b), .done(done_b), .sout(sout_b)
    );

    sliscp_perm #(.WIDTH(64), .NUM_STEPS(18), .SB_ROUNDS(8), .UNROLL(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .sin(sin64),
        .rc0(8'h00), .rc1(8'h00), .sc0(8'h00), .sc1(8'h00),
        .step_idx(step_c), .busy(busy_c), .done(done_c), .sout(sout_c)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotlh(input logic [31:0] x, input int n, input int h);
        logic [31:0] m;
        m = (h == 32) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
        return ((x << n) | (x >> (h - n))) & m;
    endfunction

    function automatic logic [63:0] sbox(input logic [63:0] x, input logic [7:0] rc, input int w, input int nr);
        logic [31:0] m, l, r, f, tmp;
        int h;
        h = w / 2;
        m = (h == 32) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
        l = 32'(x >> h) & m;
        r = 32'(x) & m;
        for (int t = 0; t < nr; t++) begin
            f   = (l & rotlh(l, 5, h)) ^ rotlh(l, 1, h);
            tmp = (r ^ f ^ (m & ~32'd1) ^ 32'(rc[t])) & m;
            r   = l;
            l   = tmp;
        end
        return ({32'd0, l} << h) | {32'd0, r};
    endfunction

    function automatic logic [255:0] model(input logic [255:0] s, input int w, input int nr, input bit zc);
        logic [63:0] wm, w0, w1, w2, w3, n1, n3, a, b;
        logic [31:0] k;
        wm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_FFFF_FFFF_FFFF;
        w0 = 64'(s >> (3 * w)) & wm;
        w1 = 64'(s >> (2 * w)) & wm;
        w2 = 64'(s >> w) & wm;
        w3 = 64'(s) & wm;
        for (int i = 0; i < 18; i++) begin
            k  = zc ? 32'd0 : rom(5'(i));
            n1 = sbox(w1, k[31:24], w, nr);
            n3 = sbox(w3, k[23:16], w, nr);
            a  = w0 ^ ((wm & ~64'hFF) | 64'(k[13:8]));
            b  = w2 ^ ((wm & ~64'hFF) | 64'(k[5:0]));
            w0 = n1;
            w1 = n3 ^ b;
            w2 = n3;
            w3 = a ^ n1;
        end
        return (256'(w0) << (3 * w)) | (256'(w1) << (2 * w)) | (256'(w2) << w) | 256'(w3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start_a = 0; start_b = 0; start_c = 0; sin48 = '0; sin64 = '0;
        #1;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_a); end
        tests++; if (step_a !== 5'd0) begin fails++; $display("FAIL reset_step: got %0d expected 0", step_a); end
        tests++; if (sout_a !== 192'd0) begin fails++; $display("FAIL reset_sout: got %0h expected 0", sout_a); end
        @(negedge clk);
        rst = 1'b0;
        tick;
    endtask

    // sin=0 on unroll 1 and unroll 2 in parallel
    task automatic test_kat_unroll;
        logic [191:0] exp;
        int d1, d2, bad_busy;
        exp = 192'(model(256'(192'd0), 48, 6, 1'b0));
        sin48 = '0; start_a = 1; start_b = 1;
        tick;
        start_a = 0; start_b = 0;
        d1 = 0; d2 = 0; bad_busy = 0;
        for (int n = 1; n <= 150 && d1 == 0; n++) begin
            if (done_a) d1 = n;
            if (done_b && d2 == 0) d2 = n;
            if (n <= 108 && busy_a !== 1'b1) bad_busy++;
            if (n == 4) begin
                tests++; if (step_a !== 5'd0) begin fails++; $display("FAIL step_u1_c4: got %0d expected 0", step_a); end
                tests++; if (step_b !== 5'd1) begin fails++; $display("FAIL step_u2_c4: got %0d expected 1", step_b); end
            end
            if (n == 7) begin
                tests++; if (step_a !== 5'd1) begin fails++; $display("FAIL step_u1_c7: got %0d expected 1", step_a); end
                tests++; if (step_b !== 5'd2) begin fails++; $display("FAIL step_u2_c7: got %0d expected 2", step_b); end
            end
            if (d1 == 0) tick;
        end
        tests++; if (d1 != 109) begin fails++; $display("FAIL done_cycle_u1: got %0d expected 109", d1); end
        tests++; if (d2 != 55) begin fails++; $display("FAIL done_cycle_u2: got %0d expected 55", d2); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL busy_window: got %0d low cycles expected 0", bad_busy); end
        tests++; if (sout_a !== exp) begin fails++; $display("FAIL kat_u1: got %0h expected %0h", sout_a, exp); end
        tests++; if (sout_b !== exp) begin fails++; $display("FAIL kat_u2: got %0h expected %0h", sout_b, exp); end
        tick;
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b expected 0", done_a); end
        tests++; if (step_a !== 5'd17) begin fails++; $display("FAIL step_hold: got %0d expected 17", step_a); end
    endtask

    // Spurious starts mid-run and during DONE are ignored
    task automatic test_start_ignored;
        logic [191:0] exp;
        int d;
        exp = 192'(model(256'(S1), 48, 6, 1'b0));
        sin48 = S1; start_a = 1;
        tick;
        start_a = 0;
        d = 0;
        for (int n = 1; n <= 150 && d == 0; n++) begin
            start_a = (n == 5 || n == 60);
            if (n == 60) sin48 = S2;
            if (done_a) begin
                d = n;
                start_a = 1;
            end
            if (d == 0) tick;
        end
        tests++; if (d != 109) begin fails++; $display("FAIL ignore_done_cycle: got %0d expected 109", d); end
        tests++; if (sout_a !== exp) begin fails++; $display("FAIL ignore_sout: got %0h expected %0h", sout_a, exp); end
        tick;
        start_a = 0;
        tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            fails++; $display("FAIL start_in_done: got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
    endtask

    // Starts in the IDLE cycle right after DONE; previous sout held through RUN
    task automatic test_back_to_back;
        logic [191:0] exp1, exp2;
        int d;
        exp1 = 192'(model(256'(S1), 48, 6, 1'b0));
        exp2 = 192'(model(256'(S2), 48, 6, 1'b0));
        sin48 = S2; start_a = 1;
        tick;
        start_a = 0;
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_a); end
        d = 0;
        for (int n = 1; n <= 150 && d == 0; n++) begin
            if (done_a) d = n;
            if (n == 50) begin
                tests++; if (sout_a !== exp1) begin fails++; $display("FAIL b2b_hold: got %0h expected %0h", sout_a, exp1); end
            end
            if (d == 0) tick;
        end
        tests++; if (d != 109) begin fails++; $display("FAIL b2b_done_cycle: got %0d expected 109", d); end
        tests++; if (sout_a !== exp2) begin fails++; $display("FAIL b2b_sout: got %0h expected %0h", sout_a, exp2); end
        tick;
    endtask

    // WIDTH=64, zero constants, all-ones input
    task automatic test_zero64;
        logic [255:0] exp;
        int d;
        exp = model({256{1'b1}}, 64, 8, 1'b1);
        sin64 = {256{1'b1}}; start_c = 1;
        tick;
        start_c = 0;
        d = 0;
        for (int n = 1; n <= 200 && d == 0; n++) begin
            if (done_c) d = n;
            if (d == 0) tick;
        end
        tests++; if (d != 145) begin fails++; $display("FAIL w64_done_cycle: got %0d expected 145", d); end
        tests++; if (sout_c !== exp) begin fails++; $display("FAIL w64_sout: got %0h expected %0h", sout_c, exp); end
        tick;
    endtask

    // Asynchronous reset mid-RUN, then no done pulse afterwards
    task automatic test_reset_midrun;
        int dones, busys;
        sin48 = S1; start_a = 1;
        tick;
        start_a = 0;
        repeat (30) tick;
        #3;
        rst = 1'b1;
        #1;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midrun_busy: got %b expected 0", busy_a); end
        tests++; if (step_a !== 5'd0) begin fails++; $display("FAIL midrun_step: got %0d expected 0", step_a); end
        tests++; if (sout_a !== 192'd0) begin fails++; $display("FAIL midrun_sout: got %0h expected 0", sout_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL midrun_done: got %b expected 0", done_a); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0; busys = 0;
        for (int n = 0; n < 150; n++) begin
            tick;
            if (done_a) dones++;
            if (busy_a) busys++;
        end
        tests++; if (dones != 0 || busys != 0) begin
            fails++; $display("FAIL post_reset_idle: got dones=%0d busy=%0d expected 0 0", dones, busys);
        end
    endtask

    initial begin
        test_reset;
        test_kat_unroll;
        test_start_ignored;
        test_back_to_back;
        test_zero64;
        test_reset_midrun;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sliscp_perm.md
Name: sliscp_perm

Overview:
- Iterative sLiSCP-light permutation core.
- Applies NUM_STEPS full steps to a 4*WIDTH-bit state. Each step is two Simeck SB boxes on words S1 and S3, constant addition on S0 and S2, and the Feistel word mix.
- Round/step constants come from an external constant ROM, addressed by step_idx.
- Sits under the SpoC mode controller, replacing a per-step datapath plus external step sequencing; supports 192-bit (WIDTH=48) and 256-bit (WIDTH=64) variants and configurable Simeck unrolling.

Parameters:
- WIDTH, 48, word width; state is 4*WIDTH; Simeck halves are WIDTH/2; legal values 48, 64.
- NUM_STEPS, 18, permutation steps per invocation.
- SB_ROUNDS, 6, Simeck rounds per SB box (8 for WIDTH=64).
- UNROLL, 1, Simeck rounds per clock; must divide SB_ROUNDS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin permutation; sampled only in IDLE
- sin  input  4*WIDTH  input state {S0,S1,S2,S3}, S0 at MSBs; captured on accepted start
- rc0  input  8  S1 box round constants for current step, bit t used in round t
- rc1  input  8  S3 box round constants for current step
- sc0  input  8  S0 step constant, bits [5:0] used
- sc1  input  8  S2 step constant, bits [5:0] used
- step_idx  output  5  current step number 0..NUM_STEPS-1, for the constant ROM
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when sout becomes valid
- sout  output  4*WIDTH  permuted state; valid from done until next accepted start

Behaviour:
- Reset (async, rst=1): state→IDLE; state register, step_idx, round counter, busy, done, sout all 0.
- FSM: IDLE -> RUN on start; RUN -> DONE after last round cycle of step NUM_STEPS-1; DONE -> IDLE unconditionally next cycle.
  - done=1 only in DONE.
  - start is accepted in IDLE only. It is ignored in RUN and DONE (no queueing).
- Accepted start: load sin into the state register; step_idx=0; round counter r=0.
- Simeck round t on a (l,r) pair of WIDTH/2 bits, applied to S1 with rc0[t] and to S3 with rc1[t]:
  - f(x) = (x & rotl(x,5)) ^ rotl(x,1)
  - c = {ones(WIDTH/2-1), rc[t]}
  - (l,r) -> (r ^ f(l) ^ c, l)
  - l is the upper half of the word.
- Each RUN cycle performs UNROLL consecutive rounds t=r..r+UNROLL-1, then r += UNROLL.
- When r reaches SB_ROUNDS in a cycle, the same cycle also applies the step mix. With S1', S3' the box outputs:
  - sc_step(sc) = {ones(WIDTH-8), 2'b00, sc[5:0]}
  - A = S0 ^ sc_step(sc0)
  - B = S2 ^ sc_step(sc1)
  - new {S0,S1,S2,S3} = {S1', S3' ^ B, S3', A ^ S1'}
  - Then r=0 and step_idx increments.
- Constants are combinational inputs. The ROM must present the values for step_idx throughout that step; the core does not register them.
- Latency: accepted start at cycle 0 → done high at cycle NUM_STEPS*SB_ROUNDS/UNROLL + 1.
  - Default: 109 cycles; with UNROLL=2: 55.
- sout updates from the state register only when entering DONE; it is held stable in IDLE and during a subsequent RUN until the next DONE.
- start asserted during DONE is ignored; start in the following IDLE cycle is accepted, giving a minimum 2-cycle gap between runs.
- Reset mid-RUN: immediate return to reset values; no done pulse.
- step_idx is held at NUM_STEPS-1 in DONE and IDLE after a run. It is reset to 0 only by rst or an accepted start.

Test Plan:
- Reset: rst=1 while RUN → busy=0, done=0, sout=0, step_idx=0 asynchronously, before the next clock edge.
- Known answer, WIDTH=48: sin=0, ROM with sLiSCP-light-192 constants → sout equals the golden software model; done exactly at cycle 109; busy high cycles 1..108.
- Zero constants, WIDTH=64, SB_ROUNDS=8: sin=all ones, rc/sc=0 → sout matches the model with c=0xFFFFFFFE words; done at cycle 145.
- start pulsed at cycles 5 and 60 of a run and during DONE → single done only; state unaffected; a new start accepted the cycle after DONE.
- UNROLL=2 vs UNROLL=1, same random sin and ROM → identical sout; done at cycle 55 vs 109; step_idx steps every 3 vs 6 cycles.
- Back-to-back: two runs with different sin → sout of run 1 held through run 2 RUN, then replaced at second done.
